// File: rtl/pe_result_drain.sv
// pe_result_drain: per-lane result holding registers drained one byte per beat
// onto a valid/ready stream with round-robin lane arbitration.
module pe_result_drain #(
  parameter  int unsigned CUBE_NUM  = 3,
  parameter  int unsigned BLOCK_NUM = 3,
  parameter  int unsigned ARRAY_NUM = 3,
  localparam int unsigned LANES     = ARRAY_NUM * BLOCK_NUM * CUBE_NUM,
  localparam int unsigned IDX_W     = $clog2(LANES)
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iClearStat,
  input  logic [8*LANES-1:0] iResult,
  input  logic [LANES-1:0]   iResultValid,
  output logic [7:0]         oData,
  output logic [IDX_W-1:0]   oLane,
  output logic               oValid,
  input  logic               iReady,
  output logic               oBusy,
  output logic               oOverflow,
  output logic [15:0]        oBeatCount
);

  logic [7:0]       hold [LANES];
  logic [LANES-1:0] pend;
  logic [IDX_W-1:0] rr_ptr;

  logic             load;
  logic             pop;
  logic [IDX_W-1:0] grant;
  logic             grant_vld;
  logic [LANES-1:0] pop_mask;
  logic [LANES-1:0] pend_nxt;
  logic             ovf_evt;

  // Lane index rr_ptr+off, wrapped into 0..LANES-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= LANES) s = s - LANES;
    return IDX_W'(s);
  endfunction

  // Round-robin search over the registered pending bits starting at rr_ptr.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!grant_vld && pend[wrap_idx(rr_ptr, i)]) begin
        grant     = wrap_idx(rr_ptr, i);
        grant_vld = 1'b1;
      end
    end
  end

  // Pop/capture bookkeeping; a capture on the popped lane keeps it pending.
  always_comb begin
    load     = !oValid || iReady;
    pop      = load && grant_vld;
    pop_mask = pop ? (LANES'(1) << grant) : '0;
    pend_nxt = (pend & ~pop_mask) | iResultValid;
    ovf_evt  = |(iResultValid & pend & ~pop_mask);
  end

  // Holding registers, output beat register, arbitration pointer and statistics.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int unsigned k = 0; k < LANES; k++) hold[k] <= '0;
      pend       <= '0;
      rr_ptr     <= '0;
      oData      <= '0;
      oLane      <= '0;
      oValid     <= 1'b0;
      oOverflow  <= 1'b0;
      oBeatCount <= '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (iResultValid[k]) hold[k] <= iResult[8*k +: 8];
      end
      pend <= pend_nxt;
      if (load) begin
        if (grant_vld) begin
          oData  <= hold[grant];
          oLane  <= grant;
          oValid <= 1'b1;
          rr_ptr <= (grant == IDX_W'(LANES - 1)) ? '0 : grant + IDX_W'(1);
        end else begin
          oValid <= 1'b0;
        end
      end
      if (iClearStat) begin
        oOverflow  <= 1'b0;
        oBeatCount <= '0;
      end else begin
        if (ovf_evt) oOverflow <= 1'b1;
        if (oValid && iReady && !(&oBeatCount)) oBeatCount <= oBeatCount + 16'd1;
      end
    end
  end

  // Busy whenever anything is pending or a beat is being presented.
  assign oBusy = (|pend) || oValid;

endmodule

// File: tb/tb_pe_result_drain.sv
// Scoreboard bench for pe_result_drain: stimulus pushes expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_pe_result_drain;

  localparam int unsigned LANES = 27;
  localparam int unsigned IDX_W = 5;

  typedef struct packed {
    logic [IDX_W-1:0] lane;
    logic [7:0]       data;
  } beat_t;

  logic               iClk = 1'b0;
  logic               iRst;
  logic               iClearStat;
  logic [8*LANES-1:0] iResult;
  logic [LANES-1:0]   iResultValid;
  logic [7:0]         oData;
  logic [IDX_W-1:0]   oLane;
  logic               oValid;
  logic               iReady;
  logic               oBusy;
  logic               oOverflow;
  logic [15:0]        oBeatCount;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  pe_result_drain dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iClearStat   (iClearStat),
    .iResult      (iResult),
    .iResultValid (iResultValid),
    .oData        (oData),
    .oLane        (oLane),
    .oValid       (oValid),
    .iReady       (iReady),
    .oBusy        (oBusy),
    .oOverflow    (oOverflow),
    .oBeatCount   (oBeatCount)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every beat accepted at the coming edge must match the queue head.
  always @(negedge iClk) begin
    if (iRst === 1'b0 && oValid === 1'b1 && iReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got lane %0d data 0x%0h expected none", oLane, oData);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_lane", 32'(oLane), 32'(e.lane));
        chk("beat_data", 32'(oData), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_lane(input int k, input logic [7:0] v);
    iResult[8*k +: 8] = v;
    iResultValid[k]   = 1'b1;
  endtask

  // Present the lanes set up with set_lane for exactly one capture edge.
  task automatic fire();
    tick();
    iResultValid = '0;
  endtask

  task automatic expect_beat(input int k, input logic [7:0] v);
    beat_t b;
    b.lane = IDX_W'(k);
    b.data = v;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask

  initial begin
    int n;
    iRst = 1'b1; iClearStat = 1'b0; iResult = '0; iResultValid = '0; iReady = 1'b0;
    ticks(2);
    iRst = 1'b0;
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_data", 32'(oData), 32'd0);
    chk("rst_lane", 32'(oLane), 32'd0);
    chk("rst_ovf", 32'(oOverflow), 32'd0);
    chk("rst_count", 32'(oBeatCount), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);

    // 1: single lane, one cycle of latency, one beat
    iReady = 1'b1;
    set_lane(5, 8'h3C); expect_beat(5, 8'h3C);
    fire();
    chk("t1_busy_after_capture", 32'(oBusy), 32'd1);
    tick();
    chk("t1_valid", 32'(oValid), 32'd1);
    tick();
    chk("t1_valid_drop", 32'(oValid), 32'd0);
    chk("t1_count", 32'(oBeatCount), 32'd1);

    // 2: all lanes at once drain back-to-back in lane order
    do_reset();
    for (int k = 0; k < LANES; k++) begin
      set_lane(k, 8'(k)); expect_beat(k, 8'(k));
    end
    fire();
    n = 0;
    do begin
      tick();
      n++;
    end while (oBusy && n < 40);
    chk("t2_busy_fall_cycle", 32'(n), 32'd28);
    chk("t2_count", 32'(oBeatCount), 32'd27);

    // 3: stalled output stays stable, double write to pending lane flags overflow
    do_reset();
    iReady = 1'b0;
    set_lane(2, 8'hAA); fire();
    tick();
    set_lane(2, 8'h11); fire();
    chk("t3_ovf_first_refill", 32'(oOverflow), 32'd0);
    set_lane(2, 8'h22); fire();
    chk("t3_stall_data", 32'(oData), 32'hAA);
    chk("t3_stall_lane", 32'(oLane), 32'd2);
    chk("t3_stall_valid", 32'(oValid), 32'd1);
    chk("t3_ovf", 32'(oOverflow), 32'd1);
    expect_beat(2, 8'hAA); expect_beat(2, 8'h22);
    iReady = 1'b1;
    ticks(4);
    chk("t3_busy", 32'(oBusy), 32'd0);
    chk("t3_count", 32'(oBeatCount), 32'd2);
    chk("t3_ovf_sticky", 32'(oOverflow), 32'd1);

    // 3b: clear coinciding with an accepted beat leaves the counter at zero
    set_lane(9, 8'h99); expect_beat(9, 8'h99);
    fire();
    tick();
    iClearStat = 1'b1;
    tick();
    iClearStat = 1'b0;
    chk("t3b_count_cleared", 32'(oBeatCount), 32'd0);
    chk("t3b_ovf_cleared", 32'(oOverflow), 32'd0);

    // 4: pointer at 25 serves 26 before 3, then resumes from 4
    do_reset();
    set_lane(24, 8'h24); expect_beat(24, 8'h24);
    fire();
    ticks(3);
    set_lane(3, 8'h03); set_lane(26, 8'h26);
    expect_beat(26, 8'h26); expect_beat(3, 8'h03);
    fire();
    ticks(4);
    set_lane(3, 8'h33); set_lane(4, 8'h44);
    expect_beat(4, 8'h44); expect_beat(3, 8'h33);
    fire();
    ticks(4);
    chk("t4_count", 32'(oBeatCount), 32'd5);

    // 5: refill on the popping edge keeps the new value, no overflow
    do_reset();
    set_lane(7, 8'h77); fire();
    set_lane(7, 8'h55); fire();
    expect_beat(7, 8'h77); expect_beat(7, 8'h55);
    tick();
    chk("t5_second_data", 32'(oData), 32'h55);
    ticks(3);
    chk("t5_ovf", 32'(oOverflow), 32'd0);
    chk("t5_count", 32'(oBeatCount), 32'd2);

    // 6: reset mid-drain discards everything still pending
    do_reset();
    for (int k = 0; k < 10; k++) set_lane(k, 8'(8'h80 + k));
    expect_beat(0, 8'h80); expect_beat(1, 8'h81); expect_beat(2, 8'h82);
    fire();
    ticks(4);
    chk("t6_count_before", 32'(oBeatCount), 32'd3);
    chk("t6_lane_before", 32'(oLane), 32'd3);
    iReady = 1'b0;
    iRst   = 1'b1;
    tick();
    chk("t6_valid", 32'(oValid), 32'd0);
    chk("t6_busy", 32'(oBusy), 32'd0);
    chk("t6_count", 32'(oBeatCount), 32'd0);
    iRst   = 1'b0;
    iReady = 1'b1;
    ticks(5);
    chk("t6_busy_after", 32'(oBusy), 32'd0);
    chk("t6_count_after", 32'(oBeatCount), 32'd0);

    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
